// File: rtl/intp_ctrl_prio.sv
// Priority interrupt controller: latches source requests, arbitrates the highest
// enabled priority above a threshold, and presents it with a valid/serviced handshake.
//
// state  | meaning
// S_IDLE | nothing presented; waiting for an eligible source
// S_ARB  | capture the winner (or fall back to idle if it vanished)
// S_WAIT | winner presented; waiting for intp_serviced_i
module intp_ctrl_prio #(
   parameter int NUM_SRC    = 16,
   parameter int ID_WIDTH   = 4,
   parameter int PRIO_WIDTH = 4,
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  pclk_i,
   input  logic                  prst_n_i,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   input  logic [DATA_WIDTH-1:0] pwdata_i,
   output logic [DATA_WIDTH-1:0] prdata_o,
   output logic                  pready_o,
   output logic                  pslverr_o,
   input  logic [NUM_SRC-1:0]    intp_active_i,
   input  logic                  intp_serviced_i,
   output logic                  intp_valid_o,
   output logic [ID_WIDTH-1:0]   intp_to_service_o,
   output logic [PRIO_WIDTH-1:0] intp_prio_o
);

   localparam int A_EN   = NUM_SRC;
   localparam int A_MODE = NUM_SRC + 1;
   localparam int A_PEND = NUM_SRC + 2;
   localparam int A_THR  = NUM_SRC + 3;
   localparam int A_STAT = NUM_SRC + 4;

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT} state_t;

   state_t                state_q, state_d;
   logic [PRIO_WIDTH-1:0] prio_q [NUM_SRC];
   logic [NUM_SRC-1:0]    enable_q, mode_q, pending_q, active_q;
   logic [PRIO_WIDTH-1:0] thresh_q;

   logic                  access, wr_en, addr_err;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [NUM_SRC-1:0]    elig, svc_clr, w1c, pend_next;
   logic                  any_elig, load_win, svc_done;
   logic [ID_WIDTH-1:0]   win_id;
   logic [PRIO_WIDTH-1:0] win_prio;
   logic                  unused_wdata;

   assign access       = psel_i & penable_i & ~pready_o;
   assign wr_en        = access & pwrite_i;
   assign addr_err     = paddr_i > ADDR_WIDTH'(A_STAT);
   assign unused_wdata = ^pwdata_i;

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (paddr_i == ADDR_WIDTH'(i)) rd_data = DATA_WIDTH'(prio_q[i]);
      if (paddr_i == ADDR_WIDTH'(A_EN))   rd_data = DATA_WIDTH'(enable_q);
      if (paddr_i == ADDR_WIDTH'(A_MODE)) rd_data = DATA_WIDTH'(mode_q);
      if (paddr_i == ADDR_WIDTH'(A_PEND)) rd_data = DATA_WIDTH'(pending_q);
      if (paddr_i == ADDR_WIDTH'(A_THR))  rd_data = DATA_WIDTH'(thresh_q);
      if (paddr_i == ADDR_WIDTH'(A_STAT))
         rd_data = DATA_WIDTH'({intp_valid_o, intp_prio_o, intp_to_service_o});
   end

   // Strict '>' while scanning upward keeps the lowest index on equal priority.
   always_comb begin
      elig     = '0;
      win_id   = '0;
      win_prio = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         elig[i] = pending_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
         if (elig[i] && (prio_q[i] > win_prio)) begin
            win_id   = ID_WIDTH'(i);
            win_prio = prio_q[i];
         end
      end
      any_elig = |elig;
   end

   always_comb begin
      state_d  = state_q;
      load_win = 1'b0;
      svc_done = 1'b0;
      case (state_q)
         S_IDLE: if (any_elig) state_d = S_ARB;
         S_ARB: begin
            load_win = any_elig;
            state_d  = any_elig ? S_WAIT : S_IDLE;
         end
         S_WAIT: if (intp_serviced_i) begin
            svc_done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Edge sources: a new rising edge beats any clear landing in the same cycle.
   always_comb begin
      svc_clr = '0;
      for (int i = 0; i < NUM_SRC; i++)
         svc_clr[i] = svc_done & (intp_to_service_o == ID_WIDTH'(i));
      w1c = (wr_en && paddr_i == ADDR_WIDTH'(A_PEND)) ? pwdata_i[NUM_SRC-1:0] : '0;
      pend_next = (~mode_q & intp_active_i)
                | (mode_q & ((intp_active_i & ~active_q) | (pending_q & ~(w1c | svc_clr))));
   end

   always_ff @(posedge pclk_i or negedge prst_n_i) begin
      if (!prst_n_i) begin
         state_q   <= S_IDLE;
         for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
         enable_q  <= '0;
         mode_q    <= '0;
         pending_q <= '0;
         active_q  <= '0;
         thresh_q  <= '0;
         prdata_o  <= '0;
         pready_o  <= 1'b0;
         pslverr_o <= 1'b0;
         intp_valid_o      <= 1'b0;
         intp_to_service_o <= '0;
         intp_prio_o       <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pend_next;
         active_q  <= intp_active_i;
         pready_o  <= access;
         pslverr_o <= access & addr_err;
         prdata_o  <= (access && !pwrite_i) ? rd_data : '0;
         if (wr_en) begin
            for (int i = 0; i < NUM_SRC; i++)
               if (paddr_i == ADDR_WIDTH'(i)) prio_q[i] <= pwdata_i[PRIO_WIDTH-1:0];
            if (paddr_i == ADDR_WIDTH'(A_EN))   enable_q <= pwdata_i[NUM_SRC-1:0];
            if (paddr_i == ADDR_WIDTH'(A_MODE)) mode_q   <= pwdata_i[NUM_SRC-1:0];
            if (paddr_i == ADDR_WIDTH'(A_THR))  thresh_q <= pwdata_i[PRIO_WIDTH-1:0];
         end
         if (load_win) begin
            intp_valid_o      <= 1'b1;
            intp_to_service_o <= win_id;
            intp_prio_o       <= win_prio;
         end else if (svc_done) begin
            intp_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_intp_ctrl_prio.sv
// Bench for intp_ctrl_prio: directed scenarios plus random traffic, all cycles
// compared against a behavioural model of the register map and handshake.
module tb_intp_ctrl_prio;

   localparam int NUM = 16;

   logic        pclk = 1'b0;
   logic        prst_n = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [5:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [15:0] active = '0;
   logic        serviced = 1'b0;
   logic        valid;
   logic [3:0]  id, pr;

   int n_chk = 0;
   int n_err = 0;

   intp_ctrl_prio dut (
      .pclk_i(pclk), .prst_n_i(prst_n),
      .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
      .pready_o(pready), .pslverr_o(pslverr),
      .intp_active_i(active), .intp_serviced_i(serviced),
      .intp_valid_o(valid), .intp_to_service_o(id), .intp_prio_o(pr)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model
   int          m_prio [NUM];
   bit [15:0]   m_en, m_mode, m_pend, m_actq, m_svc, m_w1c, m_rise;
   int          m_thresh;
   bit          m_ready, m_err, m_arming, m_valid;
   logic [31:0] m_rdata;
   int          m_id, m_pr, m_a, m_win;
   logic [31:0] m_rd;
   bit          m_acc;

   function automatic int winner();
      int best = -1;
      for (int i = 0; i < NUM; i++)
         if (m_pend[i] && m_en[i] && m_prio[i] > m_thresh)
            if (best < 0 || m_prio[i] > m_prio[best]) best = i;
      return best;
   endfunction

   always @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         for (int i = 0; i < NUM; i++) m_prio[i] = 0;
         m_en = 0; m_mode = 0; m_pend = 0; m_actq = 0; m_thresh = 0;
         m_ready = 0; m_err = 0; m_rdata = 0;
         m_arming = 0; m_valid = 0; m_id = 0; m_pr = 0;
      end else begin
         m_acc = psel && penable && !m_ready;
         m_a   = int'(paddr);
         m_rd  = 0;
         if (m_a < NUM)       m_rd = m_prio[m_a];
         else if (m_a == NUM)   m_rd = {16'h0, m_en};
         else if (m_a == NUM+1) m_rd = {16'h0, m_mode};
         else if (m_a == NUM+2) m_rd = {16'h0, m_pend};
         else if (m_a == NUM+3) m_rd = m_thresh;
         else if (m_a == NUM+4) m_rd = (int'(m_valid) << 8) | (m_pr << 4) | m_id;
         m_win = winner();
         m_svc = 0;
         if (m_valid) begin
            if (serviced) begin
               m_valid = 0;
               if (m_mode[m_id]) m_svc[m_id] = 1'b1;
            end
         end else if (m_arming) begin
            m_arming = 0;
            if (m_win >= 0) begin
               m_valid = 1; m_id = m_win; m_pr = m_prio[m_win];
            end
         end else if (m_win >= 0) begin
            m_arming = 1;
         end
         m_w1c  = (m_acc && pwrite && m_a == NUM+2) ? pwdata[15:0] : 16'h0;
         m_rise = active & ~m_actq;
         for (int i = 0; i < NUM; i++)
            if (m_mode[i]) m_pend[i] = m_rise[i] | (m_pend[i] & ~(m_w1c[i] | m_svc[i]));
            else           m_pend[i] = active[i];
         m_actq = active;
         if (m_acc && pwrite) begin
            if (m_a < NUM)         m_prio[m_a] = pwdata & 32'hF;
            else if (m_a == NUM)   m_en = pwdata[15:0];
            else if (m_a == NUM+1) m_mode = pwdata[15:0];
            else if (m_a == NUM+3) m_thresh = pwdata & 32'hF;
         end
         m_rdata = (m_acc && !pwrite && m_a <= NUM+4) ? m_rd : 32'h0;
         m_err   = m_acc && (m_a > NUM+4);
         m_ready = m_acc;
      end
   end

   always @(negedge pclk) begin
      chk("pready", pready, m_ready);
      if (m_ready) begin
         chk("prdata", prdata, m_rdata);
         chk("pslverr", pslverr, m_err);
      end
      chk("valid", valid, m_valid);
      if (m_valid) begin
         chk("id", id, m_id);
         chk("prio", pr, m_pr);
      end
   end

   task automatic apb(input bit wr, input int addr, input logic [31:0] data,
                      output logic [31:0] rd, output bit err);
      @(negedge pclk);
      psel = 1; penable = 0; pwrite = wr; paddr = 6'(addr); pwdata = data;
      @(negedge pclk);
      penable = 1;
      rd = 0; err = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge pclk);
         if (pready) begin
            rd = prdata; err = pslverr;
            break;
         end
      end
      chk("apb_done", pready, 1);
      psel = 0; penable = 0;
   endtask

   logic [31:0] rdv;
   bit          errv;

   task automatic apb_wr(input int addr, input logic [31:0] data);
      logic [31:0] r;
      bit e;
      apb(1'b1, addr, data, r, e);
   endtask

   task automatic wait_valid(input int max, output int cnt);
      cnt = 0;
      while (!valid && cnt < max) begin
         @(negedge pclk);
         cnt++;
      end
   endtask

   task automatic service();
      @(negedge pclk); serviced = 1;
      @(negedge pclk); serviced = 0;
   endtask

   task automatic count_valid(input int cycles, output int seen);
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge pclk);
         if (valid) seen++;
      end
   endtask

   int cnt, seen;
   logic [31:0] rnd;

   initial begin
      #2 prst_n = 0;
      repeat (3) @(negedge pclk);
      chk("rst_valid", valid, 0);
      chk("rst_id", id, 0);
      chk("rst_prdata", prdata, 0);
      prst_n = 1;

      // level sources 3 and 7 at equal priority: lowest index wins, 2 cycles after sampling
      apb_wr(3, 5); apb_wr(7, 5); apb_wr(NUM, 32'h88);
      @(negedge pclk); active[3] = 1; active[7] = 1;
      wait_valid(20, cnt);
      chk("t1_latency", cnt, 3);
      chk("t1_valid", valid, 1);
      chk("t1_id", id, 3);
      chk("t1_prio", pr, 5);
      @(negedge pclk); active = '0; serviced = 1;
      @(negedge pclk); serviced = 0;
      apb_wr(NUM, 0);

      // single edge pulse, serviced once, never re-presented
      apb_wr(NUM+1, 32'h4); apb_wr(2, 9); apb_wr(NUM, 32'h4);
      @(negedge pclk); active[2] = 1;
      @(negedge pclk); active[2] = 0;
      wait_valid(20, cnt);
      chk("t2_valid", valid, 1);
      chk("t2_id", id, 2);
      chk("t2_prio", pr, 9);
      service();
      apb(1'b0, NUM+2, 0, rdv, errv);
      chk("t2_pending", rdv, 0);
      count_valid(12, seen);
      chk("t2_no_repeat", seen, 0);

      // threshold: prio 6 blocked at THRESH=6, prio 7 passes
      apb_wr(NUM+3, 6); apb_wr(1, 6); apb_wr(4, 7);
      apb_wr(NUM+1, 32'h12); apb_wr(NUM, 32'h12);
      @(negedge pclk); active[1] = 1; active[4] = 1;
      @(negedge pclk); active = '0;
      wait_valid(20, cnt);
      chk("t3_valid", valid, 1);
      chk("t3_id", id, 4);
      chk("t3_prio", pr, 7);
      service();
      count_valid(12, seen);
      chk("t3_blocked", seen, 0);
      apb(1'b0, NUM+2, 0, rdv, errv);
      chk("t3_pend_src1", rdv, 32'h2);
      apb_wr(NUM+2, 32'h2);
      apb(1'b0, NUM+2, 0, rdv, errv);
      chk("t3_w1c", rdv, 0);

      // no preemption: id 9 waits until id 5 is serviced, then shows at Es+2
      apb_wr(NUM+3, 0); apb_wr(5, 3); apb_wr(9, 12);
      apb_wr(NUM+1, 32'h220); apb_wr(NUM, 32'h220);
      @(negedge pclk); active[5] = 1;
      @(negedge pclk); active[5] = 0;
      wait_valid(20, cnt);
      chk("t4_id5", id, 5);
      @(negedge pclk); active[9] = 1;
      @(negedge pclk); active[9] = 0;
      repeat (3) @(negedge pclk);
      chk("t4_hold_valid", valid, 1);
      chk("t4_hold_id", id, 5);
      @(negedge pclk); serviced = 1;
      @(negedge pclk); serviced = 0;
      chk("t4_es", valid, 0);
      @(negedge pclk);
      chk("t4_es1", valid, 0);
      @(negedge pclk);
      chk("t4_es2_valid", valid, 1);
      chk("t4_es2_id", id, 9);
      chk("t4_es2_prio", pr, 12);
      service();

      // undefined address
      apb(1'b0, NUM+9, 0, rdv, errv);
      chk("t5_rd_data", rdv, 0);
      chk("t5_rd_err", errv, 1);
      apb(1'b1, NUM+9, 32'hFFFF_FFFF, rdv, errv);
      chk("t5_wr_err", errv, 1);
      apb(1'b0, NUM, 0, rdv, errv);
      chk("t5_enable", rdv, 32'h220);
      apb(1'b0, NUM+3, 0, rdv, errv);
      chk("t5_thresh", rdv, 0);
      apb(1'b0, NUM+4, 0, rdv, errv);
      chk("t5_status", rdv, 32'h0C9);

      // async reset during presentation
      apb_wr(0, 1); apb_wr(NUM, 32'h1);
      @(negedge pclk); active[0] = 1;
      wait_valid(20, cnt);
      chk("t6_valid", valid, 1);
      @(negedge pclk);
      #2 prst_n = 0;
      #1;
      chk("t6_async_valid", valid, 0);
      chk("t6_async_id", id, 0);
      chk("t6_async_prio", pr, 0);
      chk("t6_async_ready", pready, 0);
      @(negedge pclk); prst_n = 1;
      count_valid(10, seen);
      chk("t6_idle", seen, 0);
      apb(1'b0, NUM, 0, rdv, errv);
      chk("t6_enable", rdv, 0);
      active = '0;

      // random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         @(negedge pclk);
         rnd = $urandom;
         active = active ^ (rnd[15:0] & rnd[31:16]);
         serviced = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3: apb($urandom_range(0, 1) == 1, $urandom_range(0, NUM-1), $urandom, rdv, errv);
               4: apb($urandom_range(0, 1) == 1, NUM, $urandom, rdv, errv);
               5: apb($urandom_range(0, 1) == 1, NUM+1, $urandom, rdv, errv);
               6: apb($urandom_range(0, 1) == 1, NUM+2, $urandom, rdv, errv);
               7: apb($urandom_range(0, 1) == 1, NUM+3, $urandom_range(0, 5), rdv, errv);
               8: apb(1'b0, NUM+4, 0, rdv, errv);
               default: apb($urandom_range(0, 1) == 1, $urandom_range(NUM+5, 63), $urandom, rdv, errv);
            endcase
         end
      end
      serviced = 0;
      repeat (4) @(negedge pclk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
